// File: rtl/feedback_shift_reg_pkg.sv
// Shared definitions for the feedback shift register: run-time mode
// encodings and the default feedback masks for the 3-stage configuration.
package feedback_shift_reg_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_GSHIFT = 2'b01,
      MODE_SHIFT  = 2'b10,
      MODE_LFSR   = 2'b11
   } mode_e;

   localparam logic [2:0] DEF_NOR_MASK = 3'b110;
   localparam logic [2:0] DEF_XOR_MASK = 3'b011;

endpackage

// File: rtl/feedback_shift_reg_feedback.sv
// Combinational feedback network: forms the gated-shift output Z and the
// LFSR feedback bit from the current register contents and the masks.
module fsr_feedback #(
   parameter int N = 3
) (
   input  logic [N-1:0] q,
   input  logic [N-1:0] nor_mask,
   input  logic [N-1:0] xor_mask,
   output logic         z,
   output logic         lfsr_fb
);

   // Parity term doubles as the LFSR feedback; Z adds the NOR term on top.
   always_comb begin
      lfsr_fb = ^(q & xor_mask);
      z       = (~|(q & nor_mask)) ^ lfsr_fb;
   end

endmodule

// File: rtl/feedback_shift_reg.sv
// N-stage feedback shift register with hold / gated shift / plain shift /
// LFSR modes, parallel load, lock-up escape and a saturating match counter.
// Q[N-1] is the input stage, Q[0] the output stage.
module feedback_shift_reg
   import feedback_shift_reg_pkg::*;
#(
   parameter int            N        = 3,
   parameter logic [N-1:0]  NOR_MASK = N'(DEF_NOR_MASK),
   parameter logic [N-1:0]  XOR_MASK = N'(DEF_XOR_MASK),
   parameter int            CW       = 4
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          A,
   input  logic [1:0]    Mode,
   input  logic          Load,
   input  logic [N-1:0]  LoadData,
   input  logic [N-1:0]  Pattern,
   output logic [N-1:0]  Q,
   output logic          Z,
   output logic          Match,
   output logic [CW-1:0] MatchCnt
);

   logic lfsr_fb;
   logic shift_in;

   fsr_feedback #(.N(N)) u_feedback (
      .q        (Q),
      .nor_mask (NOR_MASK),
      .xor_mask (XOR_MASK),
      .z        (Z),
      .lfsr_fb  (lfsr_fb)
   );

   assign Match = (Q == Pattern);

   // Select the bit entering the input stage; an all-zero register in LFSR
   // mode would never leave zero, so a 1 is injected instead.
   always_comb begin
      shift_in = 1'b0;
      case (mode_e'(Mode))
         MODE_GSHIFT: shift_in = A & Z;
         MODE_SHIFT:  shift_in = A;
         MODE_LFSR:   shift_in = (Q == '0) ? 1'b1 : lfsr_fb;
         default:     shift_in = 1'b0;
      endcase
   end

   // Register update: load beats any shift, hold leaves Q untouched.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         Q <= '0;
      end else if (Load) begin
         Q <= LoadData;
      end else if (Mode != MODE_HOLD) begin
         Q <= {shift_in, Q[N-1:1]};
      end
   end

   // Count shifting edges whose pre-edge contents match; saturates, cleared by load.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         MatchCnt <= '0;
      end else if (Load) begin
         MatchCnt <= '0;
      end else if ((Mode != MODE_HOLD) && Match && (MatchCnt != '1)) begin
         MatchCnt <= MatchCnt + CW'(1);
      end
   end

endmodule

// File: tb/tb_feedback_shift_reg.sv
module tb_feedback_shift_reg;

   localparam int N  = 3;
   localparam int CW = 4;
   localparam logic [2:0] NM = 3'b110;
   localparam logic [2:0] XM = 3'b011;

   logic          Clk = 1'b0;
   logic          Rst;
   logic          A;
   logic [1:0]    Mode;
   logic          Load;
   logic [N-1:0]  LoadData;
   logic [N-1:0]  Pattern;
   logic [N-1:0]  Q;
   logic          Z;
   logic          Match;
   logic [CW-1:0] MatchCnt;

   int n_total = 0;
   int n_pass  = 0;

   typedef struct {
      logic [1:0] mode;
      logic       a;
      logic [2:0] exp_q;
      logic       exp_z;
   } vec_t;

   vec_t gs_tab[8];
   vec_t lf_tab[8];

   // reference model state
   int q_m;
   int cnt_m;

   feedback_shift_reg #(.N(N), .NOR_MASK(NM), .XOR_MASK(XM), .CW(CW)) dut (
      .Clk      (Clk),
      .Rst      (Rst),
      .A        (A),
      .Mode     (Mode),
      .Load     (Load),
      .LoadData (LoadData),
      .Pattern  (Pattern),
      .Q        (Q),
      .Z        (Z),
      .Match    (Match),
      .MatchCnt (MatchCnt)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act !== exp)
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      else
         n_pass++;
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic int model_z(input int q);
      int nor_t;
      int par;
      nor_t = ((q & int'(NM)) == 0) ? 1 : 0;
      par   = $countones(q & int'(XM)) % 2;
      return nor_t ^ par;
   endfunction

   // Advance model by one rising edge using the currently applied inputs.
   task automatic model_edge();
      int in_bit;
      if (Load) begin
         q_m   = int'(LoadData);
         cnt_m = 0;
      end else if (Mode != 2'b00) begin
         if (q_m == int'(Pattern) && cnt_m < (1 << CW) - 1) cnt_m++;
         case (Mode)
            2'b01:   in_bit = (A && model_z(q_m) == 1) ? 1 : 0;
            2'b10:   in_bit = A ? 1 : 0;
            default: in_bit = (q_m == 0) ? 1 : $countones(q_m & int'(XM)) % 2;
         endcase
         q_m = (q_m / 2) + in_bit * (1 << (N - 1));
      end
   endtask

   task automatic do_reset();
      Rst = 1'b1;
      #3;
      Rst = 1'b0;
      q_m = 0;
      cnt_m = 0;
   endtask

   initial begin
      logic [2:0] gq[8] = '{3'b100, 3'b010, 3'b101, 3'b110, 3'b111, 3'b011, 3'b001, 3'b000};
      logic       gz[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      logic [2:0] lq[8] = '{3'b100, 3'b010, 3'b101, 3'b110, 3'b111, 3'b011, 3'b001, 3'b100};
      for (int i = 0; i < 8; i++) begin
         gs_tab[i] = '{mode: 2'b01, a: 1'b1, exp_q: gq[i], exp_z: gz[i]};
         lf_tab[i] = '{mode: 2'b11, a: 1'b0, exp_q: lq[i], exp_z: model_z(int'(lq[i]))};
      end

      Rst = 1'b1; A = 1'b0; Mode = 2'b00; Load = 1'b0; LoadData = '0; Pattern = 3'b111;
      #12;
      chk("reset_q", int'(Q), 0);
      chk("reset_cnt", int'(MatchCnt), 0);
      chk("reset_z", int'(Z), 1);
      chk("reset_match_ne", int'(Match), 0);
      Pattern = 3'b000;
      #1;
      chk("reset_match_eq", int'(Match), 1);
      Pattern = 3'b111;
      @(negedge Clk);
      Rst = 1'b0;

      // gated shift with A=1 from reset
      for (int i = 0; i < 8; i++) begin
         Mode = gs_tab[i].mode; A = gs_tab[i].a;
         step();
         chk($sformatf("gshift_q[%0d]", i), int'(Q), int'(gs_tab[i].exp_q));
         chk($sformatf("gshift_z[%0d]", i), int'(Z), int'(gs_tab[i].exp_z));
      end

      // drain with A=0
      Load = 1'b1; LoadData = 3'b111; Mode = 2'b01; A = 1'b0;
      step();
      Load = 1'b0;
      chk("drain_load", int'(Q), 7);
      for (int i = 0; i < 5; i++) begin
         step();
         if (i >= 2) begin
            chk($sformatf("drain_q[%0d]", i), int'(Q), 0);
            chk($sformatf("drain_z[%0d]", i), int'(Z), 1);
         end
      end

      // LFSR from reset
      Mode = 2'b00;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         Mode = lf_tab[i].mode; A = lf_tab[i].a;
         step();
         chk($sformatf("lfsr_q[%0d]", i), int'(Q), int'(lf_tab[i].exp_q));
         chk($sformatf("lfsr_z[%0d]", i), int'(Z), int'(lf_tab[i].exp_z));
      end

      // pattern 101, plain shift, A = 1,0,1,0,1
      Mode = 2'b00;
      do_reset();
      Pattern = 3'b101; Mode = 2'b10;
      begin
         logic       as[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
         logic [2:0] eq[5] = '{3'b100, 3'b010, 3'b101, 3'b010, 3'b101};
         int         ec[5] = '{0, 0, 0, 1, 1};
         for (int i = 0; i < 5; i++) begin
            A = as[i];
            step();
            chk($sformatf("pat_q[%0d]", i), int'(Q), int'(eq[i]));
            chk($sformatf("pat_match[%0d]", i), int'(Match), (eq[i] == 3'b101) ? 1 : 0);
            chk($sformatf("pat_cnt[%0d]", i), int'(MatchCnt), ec[i]);
         end
      end

      // sustained match: Q stays 000 with pattern 000
      Mode = 2'b00;
      do_reset();
      Pattern = 3'b000; Mode = 2'b10; A = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         chk($sformatf("sat_cnt[%0d]", i), int'(MatchCnt), (i < 15) ? i : 15);
      end
      // load while saturated, zero data, in LFSR mode
      Load = 1'b1; LoadData = 3'b000; Mode = 2'b11;
      step();
      Load = 1'b0;
      chk("load_sat_cnt", int'(MatchCnt), 0);
      chk("load_zero_q", int'(Q), 0);
      step();
      chk("escape_q", int'(Q), 4);
      Load = 1'b1; LoadData = 3'b011;
      step();
      Load = 1'b0;
      chk("load_over_lfsr", int'(Q), 3);

      // async reset pulse between edges in LFSR mode
      Mode = 2'b00;
      do_reset();
      Pattern = 3'b000; Mode = 2'b11;
      step();
      chk("pre_rst_cnt", int'(MatchCnt), 1);
      #3 Rst = 1'b1;
      #1;
      chk("async_rst_q", int'(Q), 0);
      chk("async_rst_cnt", int'(MatchCnt), 0);
      #1 Rst = 1'b0;
      step();
      chk("post_rst_q", int'(Q), 4);
      chk("post_rst_cnt", int'(MatchCnt), 1);

      // hold for 5 cycles with A toggling
      Load = 1'b1; LoadData = 3'b011; Pattern = 3'b011; Mode = 2'b10; A = 1'b1;
      step();
      Load = 1'b0;
      step();
      chk("hold_setup_q", int'(Q), 5);
      chk("hold_setup_cnt", int'(MatchCnt), 1);
      Mode = 2'b00;
      for (int i = 0; i < 5; i++) begin
         A = ~A;
         step();
         chk($sformatf("hold_q[%0d]", i), int'(Q), 5);
         chk($sformatf("hold_cnt[%0d]", i), int'(MatchCnt), 1);
      end

      // randomized against the reference model
      do_reset();
      for (int i = 0; i < 400; i++) begin
         A        = 1'($urandom_range(0, 1));
         Mode     = 2'($urandom_range(0, 3));
         Load     = ($urandom_range(0, 15) == 0);
         LoadData = 3'($urandom_range(0, 7));
         Pattern  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : Pattern;
         model_edge();
         step();
         chk("rnd_q", int'(Q), q_m);
         chk("rnd_cnt", int'(MatchCnt), cnt_m);
         chk("rnd_z", int'(Z), model_z(q_m));
         chk("rnd_match", int'(Match), (q_m == int'(Pattern)) ? 1 : 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
